// File: rtl/sync_arb_pkg.sv
// -----------------------------------------------------------------------------
// sync_arb_pkg
// Shared definitions for the synchronized request arbiter:
//   - arb_state_e : arbiter FSM state encoding (IDLE / BUSY / RELEASE)
//   - TO_CNT_W    : width of the per-grant busy/timeout counter; it covers
//                   the largest supported TIMEOUT_CYC of 255
// -----------------------------------------------------------------------------
package sync_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int TO_CNT_W = 8;

endpackage : sync_arb_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings one asynchronous level into the clock domain through two flops.
// A third flop holds the previous synchronized value so that a rising edge
// can be detected.
// Ports:
//   clock   in  system clock, posedge
//   reset_n in  asynchronous active-low reset
//   d_async in  asynchronous request level
//   q_sync  out synchronized level
//   rise    out one-cycle pulse on a qualified 0->1 transition of q_sync
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clock,
    input  logic reset_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_fill;

    // Two-flop synchronizer, edge-detect history flop and edge arming.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_fill  <= 2'b00;
        end else begin
            r_meta <= d_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fill <= {r_fill[0], 1'b1};
            // r_fill[1] means r_sync now holds a genuinely sampled value
            // instead of its reset value. Edges are armed only once a real
            // low has been seen, so a level held high across reset is not
            // mistaken for a new request.
            if (r_fill[1] && !r_sync) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    assign q_sync = r_sync;
    assign rise   = r_sync & ~r_prev & r_armed;

endmodule : sync_edge_det

// File: rtl/sync_req_arbiter.sv
// -----------------------------------------------------------------------------
// sync_req_arbiter
// Round-robin arbiter that gives one shared resource to N_REQ requesters.
// Requests arrive asynchronously. Each request's rising edge is latched
// into pending. The arbiter grants one requester at a time and holds the
// grant until the resource reports done or TIMEOUT_CYC busy cycles pass.
// Each grant is followed by a one-cycle RELEASE, so grant never moves
// directly from one requester to another.
// Ports:
//   clock    in  system clock, posedge
//   reset_n  in  asynchronous active-low reset
//   req_in   in  [N_REQ] asynchronous request levels
//   res_done in  resource completion, synchronous
//   grant    out [N_REQ] one-hot (or zero) grant, registered
//   grant_id out index of the granted requester, valid while busy
//   busy     out resource currently granted
//   pending  out [N_REQ] latched request events not yet served
//   timeout  out one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module sync_req_arbiter
    import sync_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_in,
    input  logic                       res_done,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [N_REQ-1:0]           pending,
    output logic                       timeout
);

    localparam int                    ID_W    = $clog2(N_REQ);
    localparam logic [TO_CNT_W-1:0]   TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]       ID_LAST = ID_W'(N_REQ - 1);

    arb_state_e          r_state;
    logic [N_REQ-1:0]    r_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic                r_busy;
    logic [N_REQ-1:0]    r_pending;
    logic                r_timeout;
    logic [TO_CNT_W-1:0] r_cnt;
    logic [ID_W-1:0]     r_rr_ptr;

    logic [N_REQ-1:0]    w_rise;
    logic [N_REQ-1:0]    w_sync;
    logic [N_REQ-1:0]    w_pend_rot;
    logic                w_sel_found;
    logic [ID_W-1:0]     w_sel_off;
    logic [ID_W:0]       w_id_sum;
    logic [ID_W-1:0]     w_sel_id;
    logic [N_REQ-1:0]    w_sel_onehot;
    logic [ID_W-1:0]     w_next_ptr;
    logic [N_REQ-1:0]    w_clr;
    logic [N_REQ-1:0]    w_pend_nxt;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sync
        sync_edge_det u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .d_async (req_in[gi]),
            .q_sync  (w_sync[gi]),
            .rise    (w_rise[gi])
        );
    end

    // Round-robin search: rotate pending so rr_ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        w_pend_rot  = N_REQ'({r_pending, r_pending} >> r_rr_ptr);
        w_sel_found = 1'b0;
        w_sel_off   = {ID_W{1'b0}};
        // Walk from the top down so the smallest offset is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_pend_rot[k]) begin
                w_sel_found = 1'b1;
                w_sel_off   = ID_W'(k);
            end else begin
                w_sel_found = w_sel_found;
                w_sel_off   = w_sel_off;
            end
        end
        w_id_sum = {1'b0, r_rr_ptr} + {1'b0, w_sel_off};
        if (w_id_sum >= (ID_W + 1)'(N_REQ)) begin
            w_sel_id = ID_W'(w_id_sum - (ID_W + 1)'(N_REQ));
        end else begin
            w_sel_id = w_id_sum[ID_W-1:0];
        end
        w_sel_onehot = {{(N_REQ - 1){1'b0}}, 1'b1} << w_sel_id;
        if (w_sel_id == ID_LAST) begin
            w_next_ptr = {ID_W{1'b0}};
        end else begin
            w_next_ptr = w_sel_id + ID_W'(1);
        end
    end

    // Pending update: clear the bit being granted and set bits for new edges.
    // A new edge on the requester being granted in this cycle re-queues it.
    always_comb begin
        if ((r_state == ST_IDLE) && w_sel_found) begin
            w_clr = w_sel_onehot;
        end else begin
            w_clr = {N_REQ{1'b0}};
        end
        // rise already implies a high synchronized level; the AND only ties the event to it.
        w_pend_nxt = (r_pending & ~w_clr) | (w_rise & w_sync);
    end

    // Arbiter FSM with registered grant, busy, timeout, counter and pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= {N_REQ{1'b0}};
            r_grant_id <= {ID_W{1'b0}};
            r_busy     <= 1'b0;
            r_pending  <= {N_REQ{1'b0}};
            r_timeout  <= 1'b0;
            r_cnt      <= {TO_CNT_W{1'b0}};
            r_rr_ptr   <= {ID_W{1'b0}};
        end else begin
            r_pending <= w_pend_nxt;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        r_state    <= ST_BUSY;
                        r_grant    <= w_sel_onehot;
                        r_grant_id <= w_sel_id;
                        r_busy     <= 1'b1;
                        r_rr_ptr   <= w_next_ptr;
                        r_cnt      <= {TO_CNT_W{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + TO_CNT_W'(1);
                    // done is checked first so it wins over a coincident timeout
                    if (res_done) begin
                        r_state <= ST_RELEASE;
                        r_grant <= {N_REQ{1'b0}};
                        r_busy  <= 1'b0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state   <= ST_RELEASE;
                        r_grant   <= {N_REQ{1'b0}};
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= {N_REQ{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign timeout  = r_timeout;

endmodule : sync_req_arbiter
